// File: rtl/seq_pkg.sv
// Shared types for the "101" serial pattern transmitter and its golden tracker.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    LAST = 2'b10,
    DONE = 2'b11
  } tx_state_t;

  // Encoding matches the downstream detector so state dumps line up.
  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10
  } trk_state_t;

endpackage

// File: rtl/seq101_tracker.sv
// Next-state and hit logic of the "101" Mealy detector, usable as a reference model.
module seq101_tracker
  import seq_pkg::*;
(
  input  trk_state_t i_state,
  input  logic       i_bit,
  output trk_state_t o_next,
  output logic       o_hit
);

  always_comb begin
    o_next = T0;
    o_hit  = 1'b0;
    case (i_state)
      T0: o_next = i_bit ? T1 : T0;
      // A second 1 drops back to T0 rather than staying in T1, as the detector does.
      T1: o_next = i_bit ? T0 : T2;
      T2: begin
        o_next = i_bit ? T1 : T0;
        o_hit  = i_bit;
      end
      default: o_next = T0;
    endcase
  end

endmodule

// File: rtl/bit_seq_tx.sv
// Serial pattern transmitter: shifts a loaded pattern out MSB-first, repeated,
// while tracking how many "101" hits the downstream detector must report.
module bit_seq_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [CNT_W-1:0] load_reps,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

  tx_state_t        r_state;
  trk_state_t       r_trk;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] r_match;
  logic             r_x;
  logic             r_xv;
  logic             r_done;

  logic [LEN_W-1:0] w_len;
  logic [CNT_W-1:0] w_reps;
  logic [IDX_W-1:0] w_last_idx;
  logic             w_bit;
  trk_state_t       w_trk_next;
  logic             w_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_len      = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
  assign w_reps     = (load_reps == '0) ? CNT_W'(1) : load_reps;
  assign w_last_idx = IDX_W'(w_len - LEN_W'(1));
  assign w_bit      = r_data[r_idx];

  seq101_tracker u_trk (
    .i_state (r_trk),
    .i_bit   (w_bit),
    .o_next  (w_trk_next),
    .o_hit   (w_hit)
  );

  // Pattern register is pure data: only captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && load_valid) r_data <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_trk      <= T0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_rep      <= '0;
      r_match    <= '0;
      r_x        <= 1'b0;
      r_xv       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_idx      <= w_last_idx;
            r_last_idx <= w_last_idx;
            r_rep      <= w_reps;
            r_match    <= '0;
            r_trk      <= T0;
            // An empty pattern skips straight to the done handshake.
            r_state    <= (w_len == '0) ? LAST : SEND;
          end
        end
        SEND: begin
          if (hold) begin
            r_xv <= 1'b0;
          end else begin
            r_x   <= w_bit;
            r_xv  <= 1'b1;
            r_trk <= w_trk_next;
            if (w_hit) r_match <= sat_inc(r_match);
            if (r_idx != '0) begin
              r_idx <= r_idx - IDX_W'(1);
            end else if (r_rep > CNT_W'(1)) begin
              r_rep <= r_rep - CNT_W'(1);
              r_idx <= r_last_idx;
            end else begin
              r_state <= LAST;
            end
          end
        end
        LAST: begin
          r_xv    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == IDLE);
  assign x          = r_x;
  assign x_valid    = r_xv;
  assign done       = r_done;
  assign match_cnt  = r_match;

endmodule

// File: tb/tb_bit_seq_tx.sv
// Randomized self-checking bench for bit_seq_tx against a bit-stream reference model.
module tb_bit_seq_tx;

  localparam int WIDTH = 16;
  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [CNT_W-1:0] load_reps;
  logic             hold;
  logic             x;
  logic             x_valid;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  int errors = 0;
  int checks = 0;

  bit_seq_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_reps  (load_reps),
    .hold       (hold),
    .x          (x),
    .x_valid    (x_valid),
    .done       (done),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Detector rule: states 0/1/2; returns next state.
  function automatic int trk_next(input int s, input bit b);
    if (s == 0) return b ? 1 : 0;
    if (s == 1) return b ? 0 : 2;
    return b ? 1 : 0;
  endfunction

  // One complete transfer. hold_mode: 0 none, 1 random, 2 two stall cycles after the first bit.
  task automatic run_xfer(input logic [WIDTH-1:0] d, input int len, input int reps,
                          input int hold_mode, input bit keep_valid);
    bit bits[$];
    int exp_m[$];
    int el, er, s, m, n, pos, c, fin;
    bit h;
    el = (len > WIDTH) ? WIDTH : len;
    er = (reps == 0) ? 1 : reps;
    for (int r = 0; r < er; r++)
      for (int i = el - 1; i >= 0; i--) bits.push_back(d[i]);
    s = 0;
    m = 0;
    foreach (bits[i]) begin
      if (s == 2 && bits[i] && m < MAXC) m++;
      s = trk_next(s, bits[i]);
      exp_m.push_back(m);
    end
    n   = bits.size();
    fin = (n == 0) ? 0 : exp_m[n-1];

    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept: got %b want 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = d;
    load_len   = LEN_W'(len);
    load_reps  = CNT_W'(reps);
    hold       = 1'b0;
    tick();
    if (!keep_valid) load_valid = 1'b0;

    pos = 0;
    c   = 0;
    while (pos < n && c < 2000) begin
      case (hold_mode)
        1:       h = ($urandom_range(0, 3) == 0);
        2:       h = (c == 1 || c == 2);
        default: h = 1'b0;
      endcase
      hold = h;
      if (keep_valid) begin
        load_data = WIDTH'($urandom);
        load_len  = LEN_W'($urandom);
        load_reps = CNT_W'($urandom);
      end
      tick();
      checks++;
      if (load_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy: got %b want 0 at bit %0d", load_ready, pos);
      end
      if (h) begin
        checks++;
        if (x_valid !== 1'b0) begin
          errors++;
          $display("FAIL xvalid_hold: got %b want 0 at bit %0d", x_valid, pos);
        end
        checks++;
        if (match_cnt !== CNT_W'(pos == 0 ? 0 : exp_m[pos-1])) begin
          errors++;
          $display("FAIL match_hold: got %0d want %0d", match_cnt, (pos == 0 ? 0 : exp_m[pos-1]));
        end
      end else begin
        checks++;
        if (x_valid !== 1'b1 || x !== bits[pos]) begin
          errors++;
          $display("FAIL bit: got x=%b v=%b want x=%b v=1 at bit %0d", x, x_valid, bits[pos], pos);
        end
        checks++;
        if (match_cnt !== CNT_W'(exp_m[pos])) begin
          errors++;
          $display("FAIL match: got %0d want %0d at bit %0d", match_cnt, exp_m[pos], pos);
        end
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_early: got %b want 0 at bit %0d", done, pos);
        end
        pos++;
      end
      c++;
    end
    if (c >= 2000) begin
      errors++;
      $display("FAIL send_timeout: got %0d bits want %0d", pos, n);
    end

    hold = 1'($urandom_range(0, 1));
    tick();
    checks++;
    if (done !== 1'b1 || x_valid !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b v=%b rdy=%b want 1 0 0", done, x_valid, load_ready);
    end
    checks++;
    if (match_cnt !== CNT_W'(fin)) begin
      errors++;
      $display("FAIL match_final: got %0d want %0d", match_cnt, fin);
    end
    hold = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || load_ready !== 1'b1 || x_valid !== 1'b0 || match_cnt !== CNT_W'(fin)) begin
      errors++;
      $display("FAIL back_idle: got done=%b rdy=%b v=%b m=%0d want 0 1 0 %0d",
               done, load_ready, x_valid, match_cnt, fin);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    load_reps  = '0;
    hold       = 1'b0;
    #12;
    checks++;
    if (load_ready !== 1'b1 || x !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0 || match_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b x=%b v=%b done=%b m=%0d want 1 0 0 0 0",
               load_ready, x, x_valid, done, match_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_xfer(16'b101, 3, 1, 0, 0);
    run_xfer(16'b10101, 5, 1, 0, 0);
  endtask

  task automatic test_reps();
    run_xfer(16'b10, 2, 3, 0, 0);
    run_xfer(16'b1101, 4, 1, 0, 0);
  endtask

  task automatic test_hold();
    run_xfer(16'b101, 3, 1, 2, 0);
  endtask

  task automatic test_len0();
    run_xfer(16'hFFFF, 0, 5, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_xfer(16'h2D5, 10, 2, 0, 1);
    run_xfer(16'b101, 3, 2, 0, 0);
  endtask

  task automatic test_clamp();
    run_xfer(16'hA5A5, 31, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    load_len   = LEN_W'(16);
    load_reps  = CNT_W'(2);
    hold       = 1'b0;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (match_cnt !== CNT_W'(1) || x_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got m=%0d v=%b want 1 1", match_cnt, x_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1 || x !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0 || match_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b x=%b v=%b done=%b m=%0d want 1 0 0 0 0",
               load_ready, x, x_valid, done, match_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_xfer(16'b1010, 4, 1, 0, 0);
  endtask

  task automatic test_saturate();
    run_xfer(16'hAAAA, 16, 4, 0, 0);
    checks++;
    if (match_cnt !== CNT_W'(MAXC)) begin
      errors++;
      $display("FAIL saturate: got %0d want %0d", match_cnt, MAXC);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++)
      run_xfer(WIDTH'($urandom), $urandom_range(0, WIDTH + 2), $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reps();
    test_hold();
    test_len0();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
